// File: rtl/dma_io_peripheral.sv
// Peripheral-side endpoint of an 8237-style DMA channel: raises DREQ, answers DACK,
// and moves bytes between a local FIFO and the DMA bus on the IOR_N/IOW_N strobes.
module dma_io_peripheral #(
    parameter int CHANNEL = 0,
    parameter int DEPTH   = 8,
    parameter int CNTW    = 16
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            dir,
    input  logic            demand,
    output logic [3:0]      DREQ,
    input  logic [3:0]      DACK,
    input  logic            IOR_N,
    input  logic            IOW_N,
    input  logic            EOP_N,
    input  logic [7:0]      DB_IN,
    output logic [7:0]      DB_OUT,
    output logic            DB_OE,
    input  logic            src_valid,
    input  logic [7:0]      src_data,
    output logic            src_ready,
    output logic            snk_valid,
    output logic [7:0]      snk_data,
    input  logic            snk_ready,
    output logic [CNTW-1:0] xfer_count,
    output logic            tc_seen,
    output logic            underrun,
    input  logic            clr
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, HOLDOFF} stateT;

    stateT state, stateNext;

    logic          ack;
    logic          dirQ, demandQ, curDir, curDemand;
    logic          iorPrev, iowPrev, rdDone, wrDone, xferDone;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;
    logic [PW:0]   count, countNext;
    logic          full, empty, busReady;
    logic          localPush, localPop, busPush, busPop, pushEn, popEn;
    logic [7:0]    pushData, wrCapture;
    logic          eopHit, lastMove, dreqBit;

    assign ack = DACK[CHANNEL];

    // Mode inputs are live while idle and frozen once a request is in flight.
    assign curDir    = (state == IDLE) ? dir    : dirQ;
    assign curDemand = (state == IDLE) ? demand : demandQ;

    assign rdDone   = ack & ~iorPrev & IOR_N;
    assign wrDone   = ack & ~iowPrev & IOW_N;
    assign xferDone = rdDone | wrDone;
    assign eopHit   = ack & ~EOP_N;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign busReady = curDir ? ~full : ~empty;

    assign localPush = ~curDir & src_valid & ~full;
    assign busPush   = curDir & wrDone & ~full;
    assign localPop  = curDir & snk_ready & ~empty;
    assign busPop    = ~curDir & rdDone & ~empty;
    assign pushEn    = localPush | busPush;
    assign popEn     = localPop | busPop;
    assign pushData  = curDir ? wrCapture : src_data;

    assign src_ready = ~full;
    assign snk_valid = curDir & ~empty;
    assign snk_data  = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (pushEn && !popEn)
            countNext = count + (PW+1)'(1);
        else if (!pushEn && popEn)
            countNext = count - (PW+1)'(1);
    end

    // A demand burst ends when the byte just moved leaves nothing more to move.
    assign lastMove = curDir ? (busPush && countNext == (PW+1)'(DEPTH))
                             : (busPop && countNext == '0);

    always_ff @(posedge CLK) begin
        if (pushEn)
            mem[wrPtr] <= pushData;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn)
                wrPtr <= wrPtr + PW'(1);
            if (popEn)
                rdPtr <= rdPtr + PW'(1);
            count <= countNext;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            iorPrev   <= 1'b1;
            iowPrev   <= 1'b1;
            wrCapture <= '0;
            dirQ      <= 1'b0;
            demandQ   <= 1'b0;
            DB_OUT    <= '0;
            DB_OE     <= 1'b0;
        end else begin
            iorPrev <= IOR_N;
            iowPrev <= IOW_N;
            if (!IOW_N && ack)
                wrCapture <= DB_IN;
            if (state == IDLE) begin
                dirQ    <= dir;
                demandQ <= demand;
            end
            // An empty FIFO leaves the last byte on the bus rather than garbage.
            if (!empty)
                DB_OUT <= mem[rdPtr];
            DB_OE <= ack & ~IOR_N & ~curDir;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            xfer_count <= '0;
            tc_seen    <= 1'b0;
            underrun   <= 1'b0;
        end else if (clr) begin
            xfer_count <= '0;
            tc_seen    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (busPop || busPush)
                xfer_count <= xfer_count + CNTW'(1);
            if (eopHit)
                tc_seen <= 1'b1;
            if (~curDir && rdDone && empty)
                underrun <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        dreqBit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (busReady && !tc_seen)
                    stateNext = REQ;
            end
            REQ: begin
                dreqBit = 1'b1;
                if (ack)
                    stateNext = XFER;
            end
            XFER: begin
                dreqBit = curDemand & busReady & EOP_N;
                if (xferDone) begin
                    if (!curDemand || lastMove)
                        stateNext = HOLDOFF;
                end else if (!ack) begin
                    stateNext = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (!ack)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (eopHit)
            stateNext = HOLDOFF;
    end

    always_comb begin
        DREQ          = '0;
        DREQ[CHANNEL] = dreqBit;
    end

endmodule
